mem_stage_ctrl: RTL and testbench

Memory-access stage of the 5-stage pipeline. It sits between the EXE/MEM pipeline register and the MEM/WB pipeline register. It turns load/store control from EXE into a request/acknowledge transaction on the data-memory port, and holds the pipeline with freeze until the access completes. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_stage_ctrl.sv | 111 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: turns EXE/MEM load/store control into a req/ack data-memory
// transaction and freezes the pipeline until it completes. Optional: MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          AW        = 6,
  parameter int          TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WB_En_in,
  input  logic          MEM_R_En_in,
  input  logic          MEM_W_En_in,
  input  logic [4:0]    dest_in,
  input  logic [31:0]   ALU_result_in,
  input  logic [31:0]   readdata_in,
  output logic          WB_En,
  output logic          MEM_R_En,
  output logic [4:0]    dest,
  output logic [31:0]   ALU_result,
  output logic [31:0]   mem_data,
  output logic          freeze,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [AW+1:0] off;
  logic          mem_op;
  logic          misaligned;

  // Only the low AW+2 bits of the offset matter; the subtraction wraps identically there.
  assign off        = ALU_result_in[AW+1:0] - ADDR_BASE[AW+1:0];
  assign mem_op     = MEM_R_En_in | MEM_W_En_in;
  assign misaligned = (off[1:0] != 2'b00);

  assign WB_En      = WB_En_in;
  assign MEM_R_En   = MEM_R_En_in;
  assign dest       = dest_in;
  assign ALU_result = ALU_result_in;

  assign mem_addr   = off[AW+1:2];
  assign mem_we     = MEM_W_En_in;
  assign mem_wdata  = readdata_in;
  assign mem_req    = (state_q == BUSY);
  assign freeze     = ((state_q == IDLE) && mem_op) || (state_q == BUSY);
  assign mem_data   = (state_q == DONE) ? rdata_q : 32'd0;
  assign err        = err_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_q;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_q  <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              state_q <= DONE;
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end else begin
              state_q <= BUSY;
`ifdef MEM_TIMEOUT_EN
              wait_q  <= 8'd0;
`endif
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            // A combined read+write is a write, so only a pure load captures data.
            if (!MEM_W_En_in) rdata_q <= mem_rdata;
            state_q <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_q == 8'(TIMEOUT - 1)) begin
            rdata_q <= 32'hDEADBEEF;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`endif
        end
        // DONE lasts one cycle so the still-presented instruction is not reissued.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: scoreboard of expected load results and
// error flag, plus freeze/request cycle counts per access.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 16;
  localparam int AW      = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          WB_En_in, MEM_R_En_in, MEM_W_En_in;
  logic [4:0]    dest_in;
  logic [31:0]   ALU_result_in, readdata_in;
  logic          WB_En, MEM_R_En;
  logic [4:0]    dest;
  logic [31:0]   ALU_result, mem_data;
  logic          freeze, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          err;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata;
  logic        model_err;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.ADDR_BASE(32'd1024), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .WB_En_in(WB_En_in), .MEM_R_En_in(MEM_R_En_in), .MEM_W_En_in(MEM_W_En_in),
    .dest_in(dest_in), .ALU_result_in(ALU_result_in), .readdata_in(readdata_in),
    .WB_En(WB_En), .MEM_R_En(MEM_R_En), .dest(dest), .ALU_result(ALU_result),
    .mem_data(mem_data), .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input logic wb, input logic r, input logic w,
                            input logic [4:0] d, input logic [31:0] alu,
                            input logic [31:0] wd);
    WB_En_in      = wb;
    MEM_R_En_in   = r;
    MEM_W_En_in   = w;
    dest_in       = d;
    ALU_result_in = alu;
    readdata_in   = wd;
  endtask

  task automatic pass_through(input logic [4:0] d, input logic [31:0] alu);
    set_inputs(1'b1, 1'b0, 1'b0, d, alu, 32'hA5A5A5A5);
    #1;
    check("pt_wb",    32'(WB_En), 32'd1);
    check("pt_mr",    32'(MEM_R_En), 32'd0);
    check("pt_dest",  32'(dest), 32'(d));
    check("pt_alu",   ALU_result, alu);
    check("pt_frz",   32'(freeze), 32'd0);
    check("pt_req",   32'(mem_req), 32'd0);
    check("pt_mdata", mem_data, 32'd0);
  endtask

  // ack_wait: BUSY cycles without ack before the ack pulse; negative means never ack.
  task automatic run_op(input string tag, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_wait, input logic [31:0] rdata);
    logic [31:0] off;
    logic        mis;
    int          exp_busy;
    int          freeze_n;
    int          req_n;
    logic        done;
    exp_t        e;
    off = addr - 32'd1024;
    mis = (off[1:0] != 2'b00);
    set_inputs(r, r, w, 5'd7, addr, wdata);
    if (mis) begin
      model_rdata = 32'd0;
      model_err   = 1'b1;
      exp_busy    = 0;
    end else if (ack_wait < 0) begin
      model_rdata = 32'hDEADBEEF;
      model_err   = 1'b1;
      exp_busy    = TIMEOUT;
    end else begin
      if (!w) model_rdata = rdata;
      exp_busy = ack_wait + 1;
    end
    e.data = model_rdata;
    e.err  = model_err;
    sb_q.push_back(e);
    freeze_n = 0;
    req_n    = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (freeze) freeze_n++;
      if (mem_req) begin
        req_n++;
        check({tag, "_addr"}, 32'(mem_addr), {26'd0, off[7:2]});
        check({tag, "_we"}, 32'(mem_we), 32'(w));
        if (req_n == 1) check({tag, "_wdata"}, mem_wdata, wdata);
      end
      if (!freeze) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_mdata"}, mem_data, e.data);
        check({tag, "_err"}, 32'(err), 32'(e.err));
      end else begin
        mem_ack   = mem_req && (ack_wait >= 0) && (req_n == ack_wait + 1);
        mem_rdata = mem_ack ? rdata : 32'hBAD0BAD0;
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_frz_cycles"}, 32'(freeze_n), 32'(exp_busy + 1));
    check({tag, "_req_cycles"}, 32'(req_n), 32'(exp_busy));
    set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_idle_req"}, 32'(mem_req), 32'd0);
    check({tag, "_idle_frz"}, 32'(freeze), 32'd0);
  endtask

  task automatic reset_mid_access();
    int hold;
    int busy_n;
`ifdef MEM_TIMEOUT_EN
    hold = 5;
`else
    hold = 40;
`endif
    busy_n = 0;
    set_inputs(1'b1, 1'b1, 1'b0, 5'd9, 32'd1032, 32'd0);
    for (int cyc = 0; cyc < 100 && busy_n < hold; cyc++) begin
      @(negedge clk);
      #1;
      if (mem_req) busy_n++;
    end
    check("rst_busy_held", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    check("rst_idle_frz", 32'(freeze), 32'd1);
    check("rst_mdata", mem_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model_rdata = 32'd0;
    model_err   = 1'b0;
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack_req", 32'(mem_req), 32'd0);
    check("stray_ack_frz", 32'(freeze), 32'd0);
    check("stray_ack_mdata", mem_data, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    model_rdata = 32'd0;
    model_err   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_frz", 32'(freeze), 32'd0);
    check("reset_mdata", mem_data, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);

    pass_through(5'd3, 32'h0000_0005);
    @(negedge clk);

    run_op("sw",        1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1, 32'h0);
    run_op("lw",        1'b1, 1'b0, 32'd1028, 32'h0,        1, 32'hCAFEF00D);
    run_op("lw_imm",    1'b1, 1'b0, 32'd1276, 32'h0,        0, 32'h0BADF00D);
    run_op("lw_wrap",   1'b1, 1'b0, 32'd1280, 32'h0,        2, 32'h11112222);
    run_op("rw_both",   1'b1, 1'b1, 32'd1020, 32'h55AA55AA, 0, 32'hFFFF0000);
    run_op("lw_mis",    1'b1, 1'b0, 32'd1025, 32'h0,        0, 32'h0);
    run_op("lw_sticky", 1'b1, 1'b0, 32'd1032, 32'h0,        1, 32'h600DD00D);
`ifdef MEM_TIMEOUT_EN
    run_op("lw_tmo",    1'b1, 1'b0, 32'd1036, 32'h0,       -1, 32'h0);
`endif
    reset_mid_access();
    run_op("sw_post_rst", 1'b0, 1'b1, 32'd1040, 32'h00000077, 0, 32'h0);
    pass_through(5'd31, 32'hFFFF_FFF0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
